// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle CPU: sequences fetch/decode/execute/memory/writeback
// and drives all datapath controls combinationally from state; memory states hold until mem_ready.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       BranchNE,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    BranchNE   = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      // PC+4 is computed every fetch cycle but only committed with the IR on mem_ready.
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = 2'b10;
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = S_EXECUTE;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_ADDI:          state_d = S_ADDIEX;
          OP_J:             state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSrc      = 2'b01;
        Branch     = (opcode == OP_BEQ);
        BranchNE   = (opcode == OP_BNE);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      // Unused encodings recover through IDLE with all controls quiet.
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: a per-instruction model expands each
// instruction into its expected per-cycle control vectors; a monitor compares every cycle.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, BranchNE;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       RegWrite, RegDst, MemtoReg, illegal_op, instr_done;
  } ov_t;

  typedef struct {
    logic       r;
    logic [5:0] op;
    logic       rdy;
    ov_t        e;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mem_ready;
  logic [5:0] opcode;
  logic       mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, BranchNE;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic       ALUSrcA, RegWrite, RegDst, MemtoReg, illegal_op, instr_done;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .Branch(Branch), .BranchNE(BranchNE), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .illegal_op(illegal_op),
    .instr_done(instr_done), .state(state)
  );

  ov_t act_w;
  assign act_w = {state, mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, BranchNE,
                  PCSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst, MemtoReg,
                  illegal_op, instr_done};

  stim_t stim_q[$];
  ov_t   exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    done_exp = 0;
  int    done_act = 0;
  int    cyc = 0;

  function automatic ov_t z(input logic [3:0] st);
    ov_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  task automatic put(input logic r, input logic [5:0] op, input logic rdy, input ov_t e);
    stim_t s;
    s.r = r; s.op = op; s.rdy = rdy; s.e = e;
    stim_q.push_back(s);
  endtask

  // Expand one instruction into per-cycle stimulus and expected outputs.
  // fw/mw: memory wait cycles in FETCH and in the data access; rst_mem: reset in first MEMRD wait.
  task automatic gen_instr(input logic [5:0] op, input int fw, input int mw, input bit rst_mem);
    ov_t o;
    for (int i = 0; i <= fw; i++) begin
      o = z(4'd1);
      o.mem_req = 1'b1; o.ALUSrcB = 2'b01; o.ALUOp = 2'b10;
      o.IRWrite = (i == fw); o.PCWrite = (i == fw);
      put(1'b0, 6'($urandom), (i == fw), o);
    end
    o = z(4'd2);
    o.ALUSrcB = 2'b11; o.ALUOp = 2'b10;
    if (!is_legal(op)) begin
      o.illegal_op = 1'b1; o.instr_done = 1'b1;
      put(1'b0, op, rb(), o);
      done_exp++;
      return;
    end
    put(1'b0, op, rb(), o);
    if (op == OP_LW || op == OP_SW) begin
      o = z(4'd3);
      o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; o.ALUOp = 2'b10;
      put(1'b0, op, rb(), o);
      for (int i = 0; i <= mw; i++) begin
        o = z((op == OP_LW) ? 4'd4 : 4'd6);
        o.mem_req = 1'b1; o.IorD = 1'b1;
        o.MemWrite = (op == OP_SW);
        o.instr_done = (op == OP_SW) && (i == mw);
        if (rst_mem && i == 0 && mw > 0) begin
          put(1'b1, op, 1'b0, o);
          put(1'b0, 6'($urandom), rb(), z(4'd0));
          return;
        end
        put(1'b0, op, (i == mw), o);
      end
      if (op == OP_SW) begin
        done_exp++;
      end else begin
        o = z(4'd5);
        o.RegWrite = 1'b1; o.MemtoReg = 1'b1; o.instr_done = 1'b1;
        put(1'b0, op, rb(), o);
        done_exp++;
      end
    end else if (op == OP_R) begin
      o = z(4'd7);
      o.ALUSrcA = 1'b1;
      put(1'b0, op, rb(), o);
      o = z(4'd8);
      o.RegWrite = 1'b1; o.RegDst = 1'b1; o.instr_done = 1'b1;
      put(1'b0, op, rb(), o);
      done_exp++;
    end else if (op == OP_BEQ || op == OP_BNE) begin
      o = z(4'd9);
      o.ALUSrcA = 1'b1; o.ALUOp = 2'b01; o.PCSrc = 2'b01;
      o.Branch = (op == OP_BEQ); o.BranchNE = (op == OP_BNE); o.instr_done = 1'b1;
      put(1'b0, op, rb(), o);
      done_exp++;
    end else if (op == OP_ADDI) begin
      o = z(4'd10);
      o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; o.ALUOp = 2'b10;
      put(1'b0, op, rb(), o);
      o = z(4'd11);
      o.RegWrite = 1'b1; o.instr_done = 1'b1;
      put(1'b0, op, rb(), o);
      done_exp++;
    end else begin
      o = z(4'd12);
      o.PCWrite = 1'b1; o.PCSrc = 2'b10; o.instr_done = 1'b1;
      put(1'b0, op, rb(), o);
      done_exp++;
    end
  endtask

  // Monitor: every cycle the DUT presents a control vector; compare against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ov_t e;
      e = exp_q.pop_front();
      total++;
      if (act_w !== e) begin
        bad++;
        $display("FAIL ctl_vec cyc=%0d state act=%0d exp=%0d vec act=%h exp=%h",
                 cyc, act_w.st, e.st, act_w, e);
      end
      if (instr_done === 1'b1) done_act++;
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal_ops [7];
    logic [5:0] op;
    stim_t s;
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    rst = 1'b1; opcode = '0; mem_ready = 1'b0;

    put(1'b0, 6'($urandom), rb(), z(4'd0));
    gen_instr(OP_R,    0, 0, 1'b0);
    gen_instr(OP_LW,   2, 2, 1'b0);
    gen_instr(OP_SW,   0, 0, 1'b0);
    gen_instr(OP_BEQ,  0, 0, 1'b0);
    gen_instr(OP_BNE,  0, 0, 1'b0);
    gen_instr(OP_ADDI, 0, 0, 1'b0);
    gen_instr(OP_J,    0, 0, 1'b0);
    gen_instr(6'b111111, 0, 0, 1'b0);
    gen_instr(OP_LW,   0, 2, 1'b1);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 6)];
      end
      gen_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    repeat (3) @(posedge clk);
    while (stim_q.size() > 0) begin
      #1;
      s = stim_q.pop_front();
      rst = s.r; opcode = s.op; mem_ready = s.rdy;
      exp_q.push_back(s.e);
      @(posedge clk);
    end
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    total++;
    if (done_act != done_exp) begin
      bad++;
      $display("FAIL instr_done_count act=%0d exp=%0d", done_act, done_exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
